// File: rtl/sd_ctrl_pkg.sv
// Shared types and constants for the SD sector controller.
package sd_ctrl_pkg;

    localparam int unsigned LBA_W                = 32;
    localparam int unsigned SECTOR_BYTES_DEFAULT = 512;
    localparam int unsigned BYTE_CNT_W           = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_XFER,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Byte counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [BYTE_CNT_W-1:0] sat_inc(input logic [BYTE_CNT_W-1:0] v);
        return (v == '1) ? v : v + BYTE_CNT_W'(1);
    endfunction

endpackage

// File: rtl/sd_timeout.sv
// Down-counter watchdog: load arms it with CYCLES-1, enable counts it down,
// expire is high in the enabled cycle where the count has reached zero.
module sd_timeout #(
    parameter int unsigned CYCLES = 100000000
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic expire
);

    localparam int unsigned W    = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [W-1:0] LOAD = W'(CYCLES - 1);

    logic [W-1:0] count;

    // Count register: load takes priority, then decrement while enabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD;
        end else if (enable && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign expire = enable && (count == '0);

endmodule

// File: rtl/sd_sector_ctrl.sv
// Single-sector read/write sequencer between a CPU-side command port and the
// hps_io sd_rd/sd_wr/sd_ack handshake, with byte counting and a watchdog.
module sd_sector_ctrl
    import sd_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000000,
    parameter int unsigned SECTOR_BYTES   = SECTOR_BYTES_DEFAULT
) (
    input  logic             clk_100m,
    input  logic             reset,
    input  logic             cmd_rd,
    input  logic             cmd_wr,
    input  logic [LBA_W-1:0] cmd_lba,
    output logic [LBA_W-1:0] sd_lba,
    output logic             sd_rd,
    output logic             sd_wr,
    input  logic             sd_ack,
    input  logic             sd_buff_wr,
    output logic             busy,
    output logic             buf_hps_owned,
    output logic             done,
    output logic             error
);

    localparam logic [BYTE_CNT_W-1:0] SECTOR_CNT = BYTE_CNT_W'(SECTOR_BYTES);

    state_t                  state, state_next;
    logic                    dir_wr, dir_wr_next;
    logic                    err_flag, err_flag_next;
    logic [BYTE_CNT_W-1:0]   byte_cnt, byte_cnt_next;
    logic [LBA_W-1:0]        lba_next;
    logic                    tmo_load, tmo_run, tmo_expire;

    sd_timeout #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk_100m),
        .reset  (reset),
        .load   (tmo_load),
        .enable (tmo_run),
        .expire (tmo_expire)
    );

    // State register.
    always_ff @(posedge clk_100m) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, datapath-next and timer control.
    always_comb begin
        state_next    = state;
        dir_wr_next   = dir_wr;
        err_flag_next = err_flag;
        byte_cnt_next = byte_cnt;
        lba_next      = sd_lba;
        tmo_load      = 1'b0;
        tmo_run       = 1'b0;
        case (state)
            ST_IDLE: begin
                // A stale ack from an aborted transfer blocks new commands.
                if (!sd_ack) begin
                    if (cmd_rd && cmd_wr) begin
                        state_next    = ST_DONE;
                        err_flag_next = 1'b1;
                    end else if (cmd_rd || cmd_wr) begin
                        state_next    = ST_REQ;
                        dir_wr_next   = cmd_wr;
                        lba_next      = cmd_lba;
                        byte_cnt_next = '0;
                        err_flag_next = 1'b0;
                        tmo_load      = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                tmo_run = 1'b1;
                if (tmo_expire) begin
                    state_next    = ST_DRAIN;
                    err_flag_next = 1'b1;
                end else if (sd_ack) begin
                    state_next = ST_XFER;
                end
            end
            ST_XFER: begin
                tmo_run = 1'b1;
                if (sd_buff_wr) begin
                    byte_cnt_next = sat_inc(byte_cnt);
                end
                if (!sd_ack) begin
                    state_next = ST_DONE;
                    if (byte_cnt_next != SECTOR_CNT) begin
                        err_flag_next = 1'b1;
                    end
                end else if (tmo_expire) begin
                    state_next    = ST_DRAIN;
                    err_flag_next = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (!sd_ack) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next    = ST_IDLE;
                err_flag_next = 1'b0;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath and registered outputs, all derived from the next state so
    // each output changes in the same cycle the state does.
    always_ff @(posedge clk_100m) begin
        if (reset) begin
            dir_wr        <= 1'b0;
            err_flag      <= 1'b0;
            byte_cnt      <= '0;
            sd_lba        <= '0;
            sd_rd         <= 1'b0;
            sd_wr         <= 1'b0;
            busy          <= 1'b0;
            buf_hps_owned <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            dir_wr        <= dir_wr_next;
            err_flag      <= err_flag_next;
            byte_cnt      <= byte_cnt_next;
            sd_lba        <= lba_next;
            sd_rd         <= (state_next == ST_REQ) && !dir_wr_next;
            sd_wr         <= (state_next == ST_REQ) && dir_wr_next;
            busy          <= (state_next != ST_IDLE);
            buf_hps_owned <= (state_next inside {ST_REQ, ST_XFER});
            done          <= (state_next == ST_DONE);
            error         <= (state_next == ST_DONE) && err_flag_next;
        end
    end

endmodule

// File: tb/tb_sd_sector_ctrl.sv
// Directed bench for sd_sector_ctrl: one DUT at the default timeout for the
// transfer scenarios, one with a 20-cycle timeout for the watchdog scenario.
module tb_sd_sector_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_rd, cmd_wr, sd_ack, sd_buff_wr;
    logic [31:0] cmd_lba, sd_lba;
    logic        sd_rd, sd_wr, busy, buf_hps_owned, done, error;

    logic        t_cmd_rd, t_cmd_wr, t_sd_ack, t_sd_buff_wr;
    logic [31:0] t_cmd_lba, t_sd_lba;
    logic        t_sd_rd, t_sd_wr, t_busy, t_buf_hps_owned, t_done, t_error;

    int checks   = 0;
    int failures = 0;
    int overlap  = 0;

    always #5 clk = ~clk;

    sd_sector_ctrl dut (
        .clk_100m      (clk),
        .reset         (reset),
        .cmd_rd        (cmd_rd),
        .cmd_wr        (cmd_wr),
        .cmd_lba       (cmd_lba),
        .sd_lba        (sd_lba),
        .sd_rd         (sd_rd),
        .sd_wr         (sd_wr),
        .sd_ack        (sd_ack),
        .sd_buff_wr    (sd_buff_wr),
        .busy          (busy),
        .buf_hps_owned (buf_hps_owned),
        .done          (done),
        .error         (error)
    );

    sd_sector_ctrl #(
        .TIMEOUT_CYCLES (20)
    ) dut_t (
        .clk_100m      (clk),
        .reset         (reset),
        .cmd_rd        (t_cmd_rd),
        .cmd_wr        (t_cmd_wr),
        .cmd_lba       (t_cmd_lba),
        .sd_lba        (t_sd_lba),
        .sd_rd         (t_sd_rd),
        .sd_wr         (t_sd_wr),
        .sd_ack        (t_sd_ack),
        .sd_buff_wr    (t_sd_buff_wr),
        .busy          (t_busy),
        .buf_hps_owned (t_buf_hps_owned),
        .done          (t_done),
        .error         (t_error)
    );

    // Strobes must never overlap on either instance.
    always @(negedge clk) begin
        if ((sd_rd && sd_wr) || (t_sd_rd && t_sd_wr)) overlap++;
    end

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({sd_rd, sd_wr, busy, buf_hps_owned, done, error} !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected 000000", {sd_rd, sd_wr, busy, buf_hps_owned, done, error});
        end
        checks++;
        if (sd_lba !== 32'h0) begin
            failures++;
            $display("FAIL reset_lba: got %h expected 00000000", sd_lba);
        end
        checks++;
        if ({t_sd_rd, t_sd_wr, t_busy, t_buf_hps_owned, t_done, t_error} !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs_t: got %b expected 000000", {t_sd_rd, t_sd_wr, t_busy, t_buf_hps_owned, t_done, t_error});
        end
    endtask

    task automatic test_read();
        int n;
        cmd_lba = 32'h10;
        cmd_rd  = 1'b1;
        @(negedge clk);
        cmd_rd  = 1'b0;
        cmd_lba = 32'hFFFF_FFFF;
        checks++;
        if ({sd_rd, sd_wr, busy, buf_hps_owned} !== 4'b1011) begin
            failures++;
            $display("FAIL read_strobe_start: got %b expected 1011", {sd_rd, sd_wr, busy, buf_hps_owned});
        end
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (sd_rd) n++;
            if (n == 3 && !sd_ack) sd_ack = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (n !== 3) begin
            failures++;
            $display("FAIL read_strobe_len: got %0d expected 3", n);
        end
        checks++;
        if ({sd_rd, buf_hps_owned, busy} !== 3'b011) begin
            failures++;
            $display("FAIL read_xfer_state: got %b expected 011", {sd_rd, buf_hps_owned, busy});
        end
        for (int i = 0; i < 512; i++) begin
            sd_buff_wr = 1'b1;
            @(negedge clk);
        end
        sd_buff_wr = 1'b0;
        sd_ack     = 1'b0;
        @(negedge clk);
        checks++;
        if ({done, error} !== 2'b10) begin
            failures++;
            $display("FAIL read_done: got done,error=%b expected 10", {done, error});
        end
        checks++;
        if (sd_lba !== 32'h10) begin
            failures++;
            $display("FAIL read_lba: got %h expected 00000010", sd_lba);
        end
        @(negedge clk);
        checks++;
        if ({done, busy} !== 2'b00) begin
            failures++;
            $display("FAIL read_idle_after: got done,busy=%b expected 00", {done, busy});
        end
    endtask

    task automatic test_short_write();
        cmd_lba = 32'h22;
        cmd_wr  = 1'b1;
        @(negedge clk);
        cmd_wr  = 1'b0;
        checks++;
        if ({sd_wr, sd_rd} !== 2'b10) begin
            failures++;
            $display("FAIL write_strobe: got wr,rd=%b expected 10", {sd_wr, sd_rd});
        end
        sd_ack = 1'b1;
        @(negedge clk);
        checks++;
        if (sd_wr !== 1'b0) begin
            failures++;
            $display("FAIL write_strobe_drop: got %b expected 0", sd_wr);
        end
        for (int i = 0; i < 511; i++) begin
            sd_buff_wr = 1'b1;
            @(negedge clk);
        end
        sd_buff_wr = 1'b0;
        sd_ack     = 1'b0;
        @(negedge clk);
        checks++;
        if ({done, error} !== 2'b11) begin
            failures++;
            $display("FAIL write_short_done: got done,error=%b expected 11", {done, error});
        end
        @(negedge clk);
        checks++;
        if (overlap !== 0) begin
            failures++;
            $display("FAIL strobe_overlap: got %0d expected 0", overlap);
        end
    endtask

    task automatic test_timeout();
        int rd_n, first_low, done_cyc, err_at, wr_seen;
        rd_n = 0; first_low = 0; done_cyc = 0; err_at = 0; wr_seen = 0;
        t_cmd_lba = 32'hABCD;
        t_cmd_rd  = 1'b1;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            t_cmd_rd = 1'b0;
            t_cmd_wr = 1'b0;
            if (cyc == 5) begin
                t_cmd_lba = 32'h5555;
                t_cmd_wr  = 1'b1;
            end
            if (t_sd_rd) rd_n++;
            if (t_sd_wr) wr_seen = 1;
            if (!t_sd_rd && first_low == 0) first_low = cyc;
            if (cyc == 21) begin
                checks++;
                if ({t_busy, t_buf_hps_owned, t_done} !== 3'b100) begin
                    failures++;
                    $display("FAIL tmo_drain: got busy,own,done=%b expected 100", {t_busy, t_buf_hps_owned, t_done});
                end
            end
            if (t_done && done_cyc == 0) begin
                done_cyc = cyc;
                err_at   = int'(t_error);
            end
            if (done_cyc != 0 && cyc > done_cyc + 1) break;
        end
        checks++;
        if (rd_n !== 20 || first_low !== 21) begin
            failures++;
            $display("FAIL tmo_strobe: got len=%0d low_at=%0d expected len=20 low_at=21", rd_n, first_low);
        end
        checks++;
        if (done_cyc !== 22 || err_at !== 1) begin
            failures++;
            $display("FAIL tmo_done: got cyc=%0d err=%0d expected cyc=22 err=1", done_cyc, err_at);
        end
        checks++;
        if (wr_seen !== 0 || t_sd_lba !== 32'hABCD) begin
            failures++;
            $display("FAIL tmo_busy_cmd: got wr=%0d lba=%h expected wr=0 lba=0000abcd", wr_seen, t_sd_lba);
        end
    endtask

    task automatic test_collision();
        cmd_lba = 32'h77;
        cmd_rd  = 1'b1;
        cmd_wr  = 1'b1;
        @(negedge clk);
        cmd_wr  = 1'b0;
        cmd_rd  = 1'b1;
        checks++;
        if ({sd_rd, sd_wr, busy, done, error} !== 5'b00111) begin
            failures++;
            $display("FAIL collision_done: got rd,wr,busy,done,err=%b expected 00111", {sd_rd, sd_wr, busy, done, error});
        end
        checks++;
        if (sd_lba !== 32'h22) begin
            failures++;
            $display("FAIL collision_lba: got %h expected 00000022", sd_lba);
        end
        @(negedge clk);
        cmd_rd = 1'b0;
        checks++;
        if ({sd_rd, busy, done} !== 3'b000) begin
            failures++;
            $display("FAIL busy_cmd_ignored: got rd,busy,done=%b expected 000", {sd_rd, busy, done});
        end
        @(negedge clk);
        checks++;
        if ({sd_rd, busy} !== 2'b00) begin
            failures++;
            $display("FAIL busy_cmd_queued: got rd,busy=%b expected 00", {sd_rd, busy});
        end
    endtask

    task automatic test_reset_mid_xfer();
        int done_seen;
        cmd_lba = 32'h55;
        cmd_rd  = 1'b1;
        @(negedge clk);
        cmd_rd  = 1'b0;
        sd_ack  = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            sd_buff_wr = 1'b1;
            @(negedge clk);
        end
        sd_buff_wr = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({sd_rd, sd_wr, busy, buf_hps_owned, done, error} !== 6'b0 || sd_lba !== 32'h0) begin
            failures++;
            $display("FAIL midreset_outputs: got %b lba=%h expected 000000 lba=00000000",
                     {sd_rd, sd_wr, busy, buf_hps_owned, done, error}, sd_lba);
        end
        cmd_lba   = 32'h66;
        cmd_rd    = 1'b1;
        done_seen = 0;
        @(negedge clk);
        cmd_rd = 1'b0;
        checks++;
        if ({sd_rd, busy} !== 2'b00) begin
            failures++;
            $display("FAIL stale_ack_reject: got rd,busy=%b expected 00", {sd_rd, busy});
        end
        repeat (3) begin
            @(negedge clk);
            if (done) done_seen = 1;
        end
        checks++;
        if (done_seen !== 0) begin
            failures++;
            $display("FAIL midreset_no_done: got %0d expected 0", done_seen);
        end
        sd_ack = 1'b0;
        @(negedge clk);
        cmd_rd = 1'b1;
        @(negedge clk);
        cmd_rd = 1'b0;
        checks++;
        if (sd_rd !== 1'b1 || sd_lba !== 32'h66) begin
            failures++;
            $display("FAIL reaccept: got rd=%b lba=%h expected rd=1 lba=00000066", sd_rd, sd_lba);
        end
        sd_ack = 1'b1;
        @(negedge clk);
        sd_ack = 1'b0;
        @(negedge clk);
        checks++;
        if ({done, error} !== 2'b11) begin
            failures++;
            $display("FAIL zero_byte_done: got done,error=%b expected 11", {done, error});
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        cmd_rd = 1'b0; cmd_wr = 1'b0; cmd_lba = '0; sd_ack = 1'b0; sd_buff_wr = 1'b0;
        t_cmd_rd = 1'b0; t_cmd_wr = 1'b0; t_cmd_lba = '0; t_sd_ack = 1'b0; t_sd_buff_wr = 1'b0;
        @(negedge clk);
        test_reset();
        test_read();
        test_short_write();
        test_timeout();
        test_collision();
        test_reset_mid_xfer();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sd_sector_ctrl.md
SD_SECTOR_CTRL -- requirements
Module: sd_sector_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 100000000, gives the cycles allowed from strobe assertion to transfer end (1 s at 100 MHz).
REQ-002 Parameter SECTOR_BYTES, default 512, gives the expected sd_buff_wr/byte count per sector.
REQ-003 Port clk_100m, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 Port reset, input, 1 bit; synchronous, active-high reset.
REQ-005 Port cmd_rd, input, 1 bit: a one-cycle pulse requesting a sector read into the buffer.
REQ-006 Port cmd_wr, input, 1 bit: a one-cycle pulse requesting a sector write from the buffer.
REQ-007 Port cmd_lba, input, 32 bits: the sector address, sampled with cmd_rd or cmd_wr.
REQ-008 Port sd_lba, output, 32 bits: the latched LBA presented to hps_io.
REQ-009 Port sd_rd, output, 1 bit: read strobe to hps_io.
REQ-010 Port sd_wr, output, 1 bit: write strobe to hps_io.
REQ-011 Port sd_ack, input, 1 bit: the hps_io transfer acknowledge.
REQ-012 Port sd_buff_wr, input, 1 bit: the hps_io buffer byte strobe.
REQ-013 Port busy, output, 1 bit: high whenever the controller is not IDLE.
REQ-014 Port buf_hps_owned, output, 1 bit: high in REQ and XFER; CPU-side buffer writes are forbidden while it is high.
REQ-015 Port done, output, 1 bit: one-cycle completion pulse.
REQ-016 Port error, output, 1 bit: valid only in the cycle done is high; 1 means the transfer failed.

Function
REQ-017 States: IDLE, REQ, XFER, DRAIN, DONE.
REQ-018 IDLE: a command is accepted only when sd_ack=0; accepting it latches cmd_lba into sd_lba and the direction, clears the byte counter and the timeout counter, and moves to REQ.
REQ-019 Simultaneous cmd_rd and cmd_wr in IDLE: neither strobe is raised; the controller goes to DONE with error=1.
REQ-020 Commands arriving outside IDLE are ignored, with no queuing.
REQ-021 REQ: sd_rd (read) or sd_wr (write) is high starting the cycle after acceptance, and stays high until sd_ack=1 is sampled.
REQ-022 In the cycle sd_ack=1 is sampled in REQ, the strobe is registered low and the state moves to XFER.
REQ-023 XFER: each sd_buff_wr=1 cycle increments a 10-bit byte counter, saturating at 1023.
REQ-024 XFER: when sd_ack=0 is sampled, the state moves to DONE; error=1 if the byte count is not SECTOR_BYTES.
REQ-025 For reads, sd_buff_wr counts bytes written into the buffer. For writes, hps_io also pulses sd_buff_wr per byte read, so the same count rule applies.
REQ-026 The timeout counter runs in REQ and XFER. When it reaches TIMEOUT_CYCLES-1, strobes drop and the state moves to DRAIN with a sticky error flag set.
REQ-027 DRAIN: the controller waits for sd_ack=0, then moves to DONE with error=1. If sd_ack is already 0, DRAIN lasts exactly one cycle.
REQ-028 DONE: done=1 for exactly one cycle, then IDLE; sd_lba holds its value until the next accept.
REQ-029 Latency with an ideal hps_io: accept at cycle N, strobe at N+1, ack at N+k, strobe low at N+k+1, ack fall at M, done at M+1.
REQ-030 sd_rd and sd_wr are never high in the same cycle.
REQ-031 Both strobes are never high while sd_ack=1, except in the single registered cycle in which the ack is first seen.

Reset
REQ-032 On reset: state=IDLE; sd_rd=0, sd_wr=0, busy=0, buf_hps_owned=0, done=0, error=0; sd_lba=0; counters=0.
REQ-033 Reset mid-transfer aborts without producing a done pulse; the REQ-018 sd_ack=0 guard prevents reacceptance until a stale ack clears.

Structure
REQ-034 Shared package sd_ctrl_pkg holds the state enum, SECTOR_BYTES_DEFAULT=512, and the LBA width constant (32).
REQ-035 There is one sub-module, sd_timeout: a parameterised down-counter with load and expire.
REQ-036 All outputs are registered.

Verification
REQ-037 Read: cmd_rd with lba=0x10; ack rises 3 cycles after the strobe; 512 sd_buff_wr; ack falls. Expect: sd_rd high for exactly 3 cycles, sd_lba=0x10, done=1 with error=0 one cycle after the ack fall.
REQ-038 Short write: cmd_wr; 511 byte strobes; ack falls. Expect: done with error=1; sd_wr is never high together with sd_rd.
REQ-039 Timeout: TIMEOUT_CYCLES=20; cmd_rd with no ack. Expect: sd_rd drops at cycle 20, DRAIN, done with error=1; no accept while busy.
REQ-040 Collision/busy: cmd_rd and cmd_wr in the same cycle, then another cmd_rd pulse while busy. Expect: the collision gives an error done with no strobe; the pulse while busy is ignored.
REQ-041 Reset mid-XFER while sd_ack is still high: all outputs are 0 next cycle; a cmd_rd is rejected until sd_ack=0, then accepted.
